// File: rtl/core_wb_unit.sv
// Writeback unit: merges the in-order pipeline result with NUM_MC multi-cycle
// result channels onto the single register-file write port. Load data is
// aligned and extended here, MC channels are arbitrated round-robin, the
// write port is registered, and a stall request is raised when an MC result
// has been waiting too long.
module core_wb_unit #(
  parameter int XLEN         = 32,
  parameter int NUM_MC       = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_pipe_valid,
  input  logic [4:0]               i_pipe_rd,
  input  logic [2:0]               i_mem_to_reg,
  input  logic [1:0]               i_d_size,
  input  logic                     i_d_unsigned,
  input  logic [$clog2(XLEN/8)-1:0] i_d_offset,
  input  logic [XLEN-1:0]          i_data_rd_data,
  input  logic [XLEN-1:0]          i_alu_result,
  input  logic [XLEN-1:0]          i_pc_plus_4,
  input  logic [XLEN-1:0]          i_imm,
  input  logic [XLEN-1:0]          i_csr_data,
  input  logic [NUM_MC-1:0]        i_mc_valid,
  input  logic [NUM_MC*5-1:0]      i_mc_rd,
  input  logic [NUM_MC*XLEN-1:0]   i_mc_data,
  output logic [NUM_MC-1:0]        o_mc_ready,
  output logic                     o_rf_we,
  output logic [4:0]               o_rf_waddr,
  output logic [XLEN-1:0]          o_rf_wdata,
  output logic                     o_stall_req
);

  localparam int OFF_W = $clog2(XLEN/8);
  localparam int PTR_W = (NUM_MC > 1) ? $clog2(NUM_MC) : 1;
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  // Shift the raw read word down to the addressed byte, then extend to XLEN.
  function automatic logic [XLEN-1:0] load_format(
    input logic [XLEN-1:0]  word,
    input logic [1:0]       size,
    input logic             is_unsigned,
    input logic [OFF_W-1:0] off
  );
    logic [XLEN-1:0]        sh;
    logic signed [7:0]      b_s;
    logic signed [15:0]     h_s;
    logic signed [31:0]     w_s;
    logic signed [XLEN-1:0] ext_s;
    logic [XLEN-1:0]        res;
    sh  = word >> {off, 3'b000};
    b_s = sh[7:0];
    h_s = sh[15:0];
    w_s = sh[31:0];
    res = word;
    case (size)
      2'b00: begin
        ext_s = XLEN'(b_s);
        res   = is_unsigned ? XLEN'(sh[7:0]) : ext_s;
      end
      2'b01: begin
        ext_s = XLEN'(h_s);
        res   = is_unsigned ? XLEN'(sh[15:0]) : ext_s;
      end
      2'b10: begin
        // A word is the whole datapath on a 32-bit core.
        if (XLEN > 32) begin
          ext_s = XLEN'(w_s);
          res   = is_unsigned ? XLEN'(sh[31:0]) : ext_s;
        end else begin
          res = word;
        end
      end
      default: res = word;
    endcase
    return res;
  endfunction

  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] starve_cnt;
  logic             pipe_own;
  logic [XLEN-1:0]  pipe_wdata;
  logic             gnt_any;
  logic [PTR_W-1:0] gnt_idx;
  logic [4:0]       mc_rd_sel;
  logic [XLEN-1:0]  mc_data_sel;

  assign pipe_own = i_pipe_valid && (i_pipe_rd != 5'd0);

  // Select the in-order result source; unused codes fall back to the ALU.
  always_comb begin
    case (i_mem_to_reg)
      3'd1:    pipe_wdata = load_format(i_data_rd_data, i_d_size, i_d_unsigned, i_d_offset);
      3'd2:    pipe_wdata = i_pc_plus_4;
      3'd3:    pipe_wdata = i_imm;
      3'd4:    pipe_wdata = i_csr_data;
      default: pipe_wdata = i_alu_result;
    endcase
  end

  // Round-robin grant: first valid channel at or after rr_ptr, only when the
  // pipe leaves the port free and never while reset is asserted.
  always_comb begin
    gnt_any    = 1'b0;
    gnt_idx    = '0;
    o_mc_ready = '0;
    if (i_rst_n && !pipe_own) begin
      for (int i = 0; i < NUM_MC; i++) begin
        if (!gnt_any && i_mc_valid[(int'(rr_ptr) + i) % NUM_MC]) begin
          gnt_any = 1'b1;
          gnt_idx = PTR_W'((int'(rr_ptr) + i) % NUM_MC);
        end
      end
      if (gnt_any) o_mc_ready[gnt_idx] = 1'b1;
    end
  end

  assign mc_rd_sel   = i_mc_rd[5*int'(gnt_idx) +: 5];
  assign mc_data_sel = i_mc_data[XLEN*int'(gnt_idx) +: XLEN];

  // ---- stage p0 -> p1: registered write port and arbitration pointer ----
  // Capture the winning result one cycle after acceptance; address/data hold when idle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_rf_we    <= 1'b0;
      o_rf_waddr <= 5'd0;
      o_rf_wdata <= '0;
      rr_ptr     <= '0;
    end else if (pipe_own) begin
      o_rf_we    <= 1'b1;
      o_rf_waddr <= i_pipe_rd;
      o_rf_wdata <= pipe_wdata;
    end else if (gnt_any) begin
      rr_ptr  <= PTR_W'((int'(gnt_idx) + 1) % NUM_MC);
      o_rf_we <= (mc_rd_sel != 5'd0);
      if (mc_rd_sel != 5'd0) begin
        o_rf_waddr <= mc_rd_sel;
        o_rf_wdata <= mc_data_sel;
      end
    end else begin
      o_rf_we <= 1'b0;
    end
  end

  // Count cycles an MC result waits without a transfer, saturating at the limit.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      starve_cnt <= '0;
    end else if (!(|i_mc_valid) || gnt_any) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign o_stall_req = (starve_cnt == CNT_W'(STARVE_LIMIT));

endmodule

// File: tb/tb_core_wb_unit.sv
// Directed testbench for core_wb_unit (XLEN=32, NUM_MC=2, STARVE_LIMIT=4).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// (registered) or 1ns after it (combinational ready).
module tb_core_wb_unit;

  logic        clk;
  logic        rst_n;
  logic        pipe_valid;
  logic [4:0]  pipe_rd;
  logic [2:0]  mem_to_reg;
  logic [1:0]  d_size;
  logic        d_unsigned;
  logic [1:0]  d_offset;
  logic [31:0] data_rd_data;
  logic [31:0] alu_result;
  logic [31:0] pc_plus_4;
  logic [31:0] imm;
  logic [31:0] csr_data;
  logic [1:0]  mc_valid;
  logic [9:0]  mc_rd;
  logic [63:0] mc_data;
  logic [1:0]  mc_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;

  int n_checks = 0;
  int n_fail   = 0;

  core_wb_unit #(.XLEN(32), .NUM_MC(2), .STARVE_LIMIT(4)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_pipe_valid   (pipe_valid),
    .i_pipe_rd      (pipe_rd),
    .i_mem_to_reg   (mem_to_reg),
    .i_d_size       (d_size),
    .i_d_unsigned   (d_unsigned),
    .i_d_offset     (d_offset),
    .i_data_rd_data (data_rd_data),
    .i_alu_result   (alu_result),
    .i_pc_plus_4    (pc_plus_4),
    .i_imm          (imm),
    .i_csr_data     (csr_data),
    .i_mc_valid     (mc_valid),
    .i_mc_rd        (mc_rd),
    .i_mc_data      (mc_data),
    .o_mc_ready     (mc_ready),
    .o_rf_we        (rf_we),
    .o_rf_waddr     (rf_waddr),
    .o_rf_wdata     (rf_wdata),
    .o_stall_req    (stall_req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic test_reset;
    rst_n      = 1'b0;
    pipe_valid = 1'b1;
    pipe_rd    = 5'd0;
    mem_to_reg = 3'd0;
    d_size     = 2'b00;
    d_unsigned = 1'b0;
    d_offset   = 2'd0;
    data_rd_data = 32'h0;
    alu_result = 32'h0;
    pc_plus_4  = 32'h0;
    imm        = 32'h0;
    csr_data   = 32'h0;
    mc_valid   = 2'b11;
    mc_rd      = {5'd10, 5'd9};
    mc_data    = {32'h0000_00B0, 32'h0000_00A0};
    #1;
    n_checks++; if (mc_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready0: got %b want 00", mc_ready); end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b want 0", rf_we); end
      n_checks++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d want 0", rf_waddr); end
      n_checks++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", rf_wdata); end
      n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall_req); end
      n_checks++; if (mc_ready !== 2'b00) begin n_fail++; $display("FAIL reset_ready: got %b want 00", mc_ready); end
    end
    // Release reset with both MC results still pending: channel 0 first.
    rst_n = 1'b1;
    #1;
    n_checks++; if (mc_ready !== 2'b01) begin n_fail++; $display("FAIL post_reset_grant0: got %b want 01", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hA0) begin
      n_fail++; $display("FAIL post_reset_write0: got we=%b x%0d=%h want we=1 x9=000000a0", rf_we, rf_waddr, rf_wdata); end
    mc_valid = 2'b10;
    #1;
    n_checks++; if (mc_ready !== 2'b10) begin n_fail++; $display("FAIL post_reset_grant1: got %b want 10", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd10 || rf_wdata !== 32'hB0) begin
      n_fail++; $display("FAIL post_reset_write1: got we=%b x%0d=%h want we=1 x10=000000b0", rf_we, rf_waddr, rf_wdata); end
    mc_valid   = 2'b00;
    pipe_valid = 1'b0;
    #1;
    n_checks++; if (mc_ready !== 2'b00) begin n_fail++; $display("FAIL idle_ready: got %b want 00", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd10 || rf_wdata !== 32'hB0) begin
      n_fail++; $display("FAIL idle_hold: got we=%b x%0d=%h want we=0 x10=000000b0", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_load;
    logic [1:0]  sz  [6] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b01};
    logic        uns [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [1:0]  off [6] = '{2'd3, 2'd2, 2'd0, 2'd1, 2'd0, 2'd2};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_80FF, 32'h80FF_1234,
                             32'h0000_0012, 32'h0000_1234, 32'hFFFF_80FF};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pipe_valid   = 1'b1;
      pipe_rd      = 5'(i + 1);
      mem_to_reg   = 3'd1;
      data_rd_data = 32'h80FF_1234;
      d_size       = sz[i];
      d_unsigned   = uns[i];
      d_offset     = off[i];
      @(negedge clk);
      n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'(i + 1) || rf_wdata !== exp[i]) begin
        n_fail++; $display("FAIL load_%0d: got we=%b x%0d=%h want we=1 x%0d=%h", i, rf_we, rf_waddr, rf_wdata, i + 1, exp[i]); end
    end
    pipe_valid = 1'b0;
  endtask

  task automatic test_sources;
    logic [2:0]  src [6] = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    logic [31:0] exp [6] = '{32'h11, 32'h104, 32'h5A, 32'hC5, 32'h11, 32'h11};
    alu_result = 32'h11;
    pc_plus_4  = 32'h104;
    imm        = 32'h5A;
    csr_data   = 32'hC5;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      pipe_valid = 1'b1;
      pipe_rd    = 5'd20;
      mem_to_reg = src[i];
      @(negedge clk);
      n_checks++; if (rf_we !== 1'b1 || rf_wdata !== exp[i]) begin
        n_fail++; $display("FAIL source_%0d: got we=%b data=%h want we=1 data=%h", src[i], rf_we, rf_wdata, exp[i]); end
    end
    pipe_valid = 1'b0;
  endtask

  task automatic test_pipe_priority;
    @(negedge clk);
    pipe_valid = 1'b1;
    pipe_rd    = 5'd5;
    mem_to_reg = 3'd0;
    alu_result = 32'h11;
    mc_valid   = 2'b01;
    mc_rd      = {5'd0, 5'd7};
    mc_data    = {32'h0, 32'h22};
    #1;
    n_checks++; if (mc_ready !== 2'b00) begin n_fail++; $display("FAIL prio_ready_blocked: got %b want 00", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h11) begin
      n_fail++; $display("FAIL prio_pipe_write: got we=%b x%0d=%h want we=1 x5=00000011", rf_we, rf_waddr, rf_wdata); end
    pipe_valid = 1'b0;
    #1;
    n_checks++; if (mc_ready !== 2'b01) begin n_fail++; $display("FAIL prio_mc_ready: got %b want 01", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22) begin
      n_fail++; $display("FAIL prio_mc_write: got we=%b x%0d=%h want we=1 x7=00000022", rf_we, rf_waddr, rf_wdata); end
    mc_valid = 2'b00;
  endtask

  task automatic test_rd_zero;
    // rr pointer now points at channel 1.
    @(negedge clk);
    pipe_valid = 1'b1;
    pipe_rd    = 5'd0;
    mc_valid   = 2'b10;
    mc_rd      = {5'd0, 5'd0};
    mc_data    = {32'h99, 32'h0};
    #1;
    n_checks++; if (mc_ready !== 2'b10) begin n_fail++; $display("FAIL rd0_ready: got %b want 10", mc_ready); end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || rf_wdata !== 32'h22) begin
      n_fail++; $display("FAIL rd0_no_write: got we=%b x%0d=%h want we=0 x7=00000022", rf_we, rf_waddr, rf_wdata); end
    mc_valid   = 2'b00;
    pipe_valid = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_checks++; if (rf_we !== 1'b1 || rf_waddr !== (((i - 1) % 2 == 0) ? 5'd11 : 5'd12)) begin
          n_fail++; $display("FAIL rr_write_%0d: got we=%b x%0d", i - 1, rf_we, rf_waddr); end
      end
      pipe_valid = 1'b0;
      mc_valid   = 2'b11;
      mc_rd      = {5'd12, 5'd11};
      mc_data    = {32'hC12, 32'hC11};
      #1;
      n_checks++; if (mc_ready !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
        n_fail++; $display("FAIL rr_grant_%0d: got %b want %b", i, mc_ready, (i % 2 == 0) ? 2'b01 : 2'b10); end
    end
    @(negedge clk);
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'hC12) begin
      n_fail++; $display("FAIL rr_write_last: got we=%b x%0d=%h want we=1 x12=00000c12", rf_we, rf_waddr, rf_wdata); end
    mc_valid = 2'b00;
  endtask

  task automatic test_starvation;
    @(negedge clk);
    pipe_valid = 1'b1;
    pipe_rd    = 5'd4;
    mem_to_reg = 3'd0;
    alu_result = 32'h44;
    mc_valid   = 2'b01;
    mc_rd      = {5'd0, 5'd13};
    mc_data    = {32'h0, 32'h55};
    #1;
    n_checks++; if (stall_req !== 1'b0 || mc_ready !== 2'b00) begin
      n_fail++; $display("FAIL starve_start: got stall=%b ready=%b want 0 00", stall_req, mc_ready); end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      n_checks++; if (stall_req !== (c >= 4)) begin
        n_fail++; $display("FAIL starve_cycle_%0d: got %b want %b", c, stall_req, (c >= 4)); end
    end
    pipe_valid = 1'b0;
    #1;
    n_checks++; if (mc_ready !== 2'b01) begin n_fail++; $display("FAIL starve_release_ready: got %b want 01", mc_ready); end
    @(negedge clk);
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_clear: got %b want 0", stall_req); end
    n_checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd13 || rf_wdata !== 32'h55) begin
      n_fail++; $display("FAIL starve_write: got we=%b x%0d=%h want we=1 x13=00000055", rf_we, rf_waddr, rf_wdata); end
    mc_valid = 2'b00;
  endtask

  initial begin
    test_reset;
    test_load;
    test_sources;
    test_pipe_priority;
    test_rd_zero;
    test_back_to_back;
    test_starvation;
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
